// File: rtl/mpt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mpt_pkg                                                      |
// | Description : Shared types for the MPT walker control unit and its stage   |
// |               buffers: flush command/status encodings, the stage FSM state |
// |               enum, and the control/status port declaration macros.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

// Port declaration helpers so every stage binds one index of the control
// unit's command/status arrays with identical widths.
`ifndef MPTW_CTRL_STATUS_PORT_MACROS
`define MPTW_CTRL_STATUS_PORT_MACROS
`define MPTW_FLUSH_CTRL_IN(name)    input  logic [$bits(mpt_pkg::mptw_flush_ctrl_e)-1:0]   name
`define MPTW_FLUSH_STATUS_OUT(name) output logic [$bits(mpt_pkg::mptw_flush_status_e)-1:0] name
`endif

package mpt_pkg;

  // Flush command from the control unit; bit 1 = drop all, bit 0 = drop speculative.
  typedef enum logic [1:0] {
    MPT_FLUSH_NONE = 2'b00,
    MPT_FLUSH_SPEC = 2'b01,
    MPT_FLUSH_ALL  = 2'b10
  } mptw_flush_ctrl_e;

  // All-ones means completed so the control unit can AND-reduce its status array.
  typedef enum logic {
    MPT_FLUSH_NOT_COMPLETED = 1'b0,
    MPT_FLUSHED_COMPLETED   = 1'b1
  } mptw_flush_status_e;

  typedef enum logic [1:0] {
    STAGE_RUN      = 2'd0,
    STAGE_FLUSHING = 2'd1,
    STAGE_DONE     = 2'd2
  } mpt_stage_state_e;

  localparam int unsigned C_STAGE_DEPTH = 2;

  // An entry survives a flush unless the ALL bit is set, or the SPEC bit is
  // set and the entry is speculative. A command with both bits set therefore
  // behaves as ALL.
  function automatic logic flush_keeps_entry(logic [1:0] cmd, logic spec);
    return ~cmd[1] & ~(cmd[0] & spec);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mpt_stage_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mpt_stage_buffer                                             |
// | Description : Flushable two-entry elastic buffer between MPT walker        |
// |               pipeline stages. Full-throughput valid/ready streaming,      |
// |               ALL/SPEC flush with in-order compaction of survivors, and    |
// |               a completion status back to the walker control unit.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mpt_stage_buffer
  import mpt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  `MPTW_FLUSH_CTRL_IN(flush_ctrl_i),
  `MPTW_FLUSH_STATUS_OUT(flush_status_o),
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_spec_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_spec_o,
  output logic                  busy_o
);

  // The slot/compaction logic below is written for exactly two entries.
  if (DEPTH != C_STAGE_DEPTH) begin : g_depth_check
    $error("mpt_stage_buffer: DEPTH must be 2");
  end

  mpt_stage_state_e      r_state;
  mpt_stage_state_e      w_state_next;
  logic                  w_latch_cmd;
  logic [1:0]            r_cmd;

  // Slot 0 is the head, slot 1 the tail; a valid tail implies a valid head.
  logic [1:0]            r_valid;
  logic [1:0]            r_spec;
  logic [DATA_WIDTH-1:0] r_data [C_STAGE_DEPTH];

  logic                  w_cmd_none;
  logic                  w_run;
  logic [1:0]            w_count;
  logic                  w_push;
  logic                  w_pop;
  logic [1:0]            w_keep;

  assign w_cmd_none = (flush_ctrl_i == MPT_FLUSH_NONE);
  assign w_run      = (r_state == STAGE_RUN);
  assign w_count    = {1'b0, r_valid[0]} + {1'b0, r_valid[1]};

  // Handshakes are suppressed the moment a command appears, so the cycle that
  // moves the FSM into FLUSHING never transfers anything.
  assign s_ready_o = w_run & w_cmd_none & (w_count < 2'(C_STAGE_DEPTH));
  assign m_valid_o = w_run & w_cmd_none & r_valid[0];
  assign m_data_o  = r_data[0];
  assign m_spec_o  = r_spec[0];

  assign w_push = s_valid_i & s_ready_o;
  assign w_pop  = m_valid_o & m_ready_i;

  assign w_keep[0] = r_valid[0] & flush_keeps_entry(r_cmd, r_spec[0]);
  assign w_keep[1] = r_valid[1] & flush_keeps_entry(r_cmd, r_spec[1]);

  assign flush_status_o = (r_state == STAGE_DONE) ? MPT_FLUSHED_COMPLETED
                                                  : MPT_FLUSH_NOT_COMPLETED;
  assign busy_o = r_valid[0] | r_valid[1] | ~w_run;

  // State register plus the command latched when a flush starts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= STAGE_RUN;
      r_cmd   <= MPT_FLUSH_NONE;
    end else begin
      r_state <= w_state_next;
      if (w_latch_cmd) begin
        r_cmd <= flush_ctrl_i;
      end
    end
  end

  // Next state: one FLUSHING cycle, then DONE until the command drops. A
  // different command arriving while in DONE starts another flush.
  always_comb begin
    w_state_next = r_state;
    w_latch_cmd  = 1'b0;
    case (r_state)
      STAGE_RUN: begin
        if (!w_cmd_none) begin
          w_state_next = STAGE_FLUSHING;
          w_latch_cmd  = 1'b1;
        end
      end
      STAGE_FLUSHING: begin
        w_state_next = STAGE_DONE;
      end
      STAGE_DONE: begin
        if (w_cmd_none) begin
          w_state_next = STAGE_RUN;
        end else if (flush_ctrl_i != r_cmd) begin
          w_state_next = STAGE_FLUSHING;
          w_latch_cmd  = 1'b1;
        end
      end
      default: begin
        w_state_next = STAGE_RUN;
      end
    endcase
  end

  // Slot storage: streaming push/pop in RUN, filter-and-compact in FLUSHING.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid   <= 2'b00;
      r_spec    <= 2'b00;
      r_data[0] <= '0;
      r_data[1] <= '0;
    end else if (r_state == STAGE_FLUSHING) begin
      if (w_keep[0]) begin
        // Head survives in place; tail stays behind it only if it survives too.
        r_valid[1] <= w_keep[1];
      end else begin
        // Head dropped: the tail (if kept) slides forward to stay in order.
        r_valid[0] <= w_keep[1];
        r_spec[0]  <= r_spec[1];
        r_data[0]  <= r_data[1];
        r_valid[1] <= 1'b0;
      end
    end else if (w_pop) begin
      if (w_push) begin
        // Pop with push is only possible at one entry: the new item is the head.
        r_spec[0] <= s_spec_i;
        r_data[0] <= s_data_i;
      end else begin
        r_valid[0] <= r_valid[1];
        r_spec[0]  <= r_spec[1];
        r_data[0]  <= r_data[1];
        r_valid[1] <= 1'b0;
      end
    end else if (w_push) begin
      if (!r_valid[0]) begin
        r_valid[0] <= 1'b1;
        r_spec[0]  <= s_spec_i;
        r_data[0]  <= s_data_i;
      end else begin
        r_valid[1] <= 1'b1;
        r_spec[1]  <= s_spec_i;
        r_data[1]  <= s_data_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mpt_stage_buffer.md
# mpt_stage_buffer

Flushable two-entry elastic buffer that sits between consecutive MPT walker pipeline stages. It is the slave side of one control/status port pair of the walker control unit. It moves payloads with a valid/ready handshake at full throughput and obeys the flush command from its control port: it discards all entries, or only the speculative ones. It reports completion on its status port so the control unit can leave its flush state.

## Interface
- `DATA_WIDTH`, 64: payload width (PTE/address bundle).
- `DEPTH`, 2: entry count. Fixed at 2; other values are rejected by elaboration assertion.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. Asynchronous, active-low.
- `flush_ctrl_i`  in  $bits(mptw_flush_ctrl_e)  flush command from the control unit.
- `flush_status_o`  out  $bits(mptw_flush_status_e)  flush status to the control unit.
- `s_valid_i`  in  1  upstream valid.
- `s_ready_o`  out  1  upstream ready.
- `s_data_i`  in  DATA_WIDTH  upstream payload.
- `s_spec_i`  in  1  payload is speculative.
- `m_valid_o`  out  1  downstream valid.
- `m_ready_i`  in  1  downstream ready.
- `m_data_o`  out  DATA_WIDTH  head payload.
- `m_spec_o`  out  1  head speculative bit.
- `busy_o`  out  1  at least one entry is valid, or a flush is in progress.

## Operation
- Storage is two slots (head, tail), each holding valid, spec and data. The FIFO order is preserved.
- The FSM has three states.
  - **RUN**: normal streaming.
  - **FLUSHING**: one cycle. Entries are cleared.
  - **DONE**: the flush is complete, waiting for the command to drop.
- RUN:
  - `s_ready_o` = (count < 2) and (flush_ctrl_i == NONE).
  - `m_valid_o` = (count > 0) and (flush_ctrl_i == NONE).
  - An input handshake writes the tail, or the head if the buffer is empty.
  - An output handshake pops the head and the tail shifts into it.
  - A push and a pop in the same cycle leave the count unchanged.
  - flush_ctrl_i != NONE moves to FLUSHING on the next edge. No handshake occurs in that cycle.
- FLUSHING:
  - Ready and valid are low.
  - On ALL, every slot is invalidated.
  - On SPEC, only slots with spec=1 are invalidated. Survivors compact to the head in order, e.g. [spec, nonspec] becomes [nonspec, empty].
  - The command is latched on entry to FLUSHING. If ALL and SPEC are both seen, ALL wins.
  - Next state is DONE.
- DONE:
  - `flush_status_o` = MPT_FLUSHED_COMPLETED. In every other state it is MPT_FLUSH_NOT_COMPLETED.
  - Ready and valid are low.
  - The FSM returns to RUN on the first cycle with flush_ctrl_i == NONE.
  - A new non-NONE command seen while in DONE re-enters FLUSHING.
- `m_valid_o` may drop without a handshake only because of a flush. This is the sole exception to the rule that valid is held until accepted.
- `m_spec_o` and `m_data_o` are driven from the head slot. Their value is don't-care while `m_valid_o` is low.

## Timing
- Reset, asynchronous: state = RUN, both slots invalid.
  - `s_ready_o` = 1, `m_valid_o` = 0, `flush_status_o` = NOT_COMPLETED, `busy_o` = 0.
  - `m_data_o` and `m_spec_o` = 0.
- Latency: a payload accepted at edge N is visible on `m_valid_o` in cycle N+1.
- Throughput: one transfer per cycle with `m_ready_i` held high.
- Backpressure: with `m_ready_i` low, two entries are absorbed and then `s_ready_o` falls.
- Flush latency: command high in cycle C gives FLUSHING in C+1 and `flush_status_o` COMPLETED from C+2, held until the command returns to NONE.
- `s_ready_o` and `m_valid_o` depend combinationally on `flush_ctrl_i`. `flush_ctrl_i` is a register output of the control unit, so there is no loop.
- Reset asserted mid-flush or mid-transfer clears everything immediately. No status pulse is produced.

## Structure
- These belong in `mpt_pkg`:
  - `mptw_flush_ctrl_e`: NONE=2'b00, SPEC=2'b01, ALL=2'b10.
  - `mptw_flush_status_e`: NOT_COMPLETED=1'b0, FLUSHED_COMPLETED=1'b1. The all-ones value means completed, which matches the control unit's AND-reduction.
  - The stage FSM state enum `mpt_stage_state_e`.
- There is no sub-module. The slot compaction logic stays inline.
- Control and status ports are exposed using the shared control/status port macros, so the block binds one index of the control unit's port arrays.

## Test plan
- Reset, then stream 0x1..0x8 with `m_ready_i`=1: outputs 0x1..0x8 in order, each one cycle after its input, with no bubbles.
- Hold `m_ready_i`=0, push 0xA and 0xB: `s_ready_o` falls after the second push. Release `m_ready_i`: 0xA then 0xB come out, and `s_ready_o` rises in the cycle after the first pop.
- Fill with [0xA spec=0, 0xB spec=1] and command SPEC: `flush_status_o`=1 two cycles later. After the command returns to NONE, only 0xA is output.
- Fill with [0xC spec=1, 0xD spec=0] and command SPEC: 0xD is compacted to the head and is the only output.
- Fill both slots and command ALL, holding it for 5 cycles: status is high from cycle 2 through the last command cycle, then returns to RUN. `busy_o`=0 and no output occurs.
- Assert `rst_ni` low during FLUSHING: outputs take their reset values asynchronously. After release, 0x55 streams normally.
